// File: rtl/controle_jogada_if.sv
// Handshake bundle between the game control unit and the move-capture sequencer.
// The master side is the game FSM and switches; the slave side is controle_jogada.
interface controle_jogada_if #(
  parameter int N_CHAVES = 6
);
  logic [N_CHAVES-1:0] chaves;
  logic                iniciar_rodada;
  logic                ack_jogada;
  logic                enable_reg_jogada;
  logic                reset_reg_jogada;
  logic                jogada_pronta;
  logic                timeout_jogada;
  logic [2:0]          estado_dbg;

  modport master (
    output chaves, iniciar_rodada, ack_jogada,
    input  enable_reg_jogada, reset_reg_jogada, jogada_pronta, timeout_jogada, estado_dbg
  );

  modport slave (
    input  chaves, iniciar_rodada, ack_jogada,
    output enable_reg_jogada, reset_reg_jogada, jogada_pronta, timeout_jogada, estado_dbg
  );
endinterface

// File: rtl/controle_jogada.sv
// Move-capture sequencer: clears the move register, debounces the switches, fires one
// capture strobe, handshakes the move to the game FSM and waits for switch release.
module controle_jogada #(
  parameter int N_CHAVES        = 6,
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  controle_jogada_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CICLOS);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CICLOS);
  localparam logic [DW-1:0] D_UM  = DW'(1);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    LIMPA      = 3'd1,
    ESPERA     = 3'd2,
    ESTABILIZA = 3'd3,
    REGISTRA   = 3'd4,
    PRONTA     = 3'd5,
    SOLTA      = 3'd6,
    EXPIROU    = 3'd7
  } estado_t;

  estado_t             estado, prox;
  logic [N_CHAVES-1:0] sync_p0, chaves_s;
  logic [N_CHAVES-1:0] amostra, amostra_prox;
  logic [TW-1:0]       t_cnt, t_prox, t_inc;
  logic [DW-1:0]       d_cnt, d_prox, d_inc;
  logic                expira, zero_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= OCIOSO;
      sync_p0  <= '0;
      chaves_s <= '0;
      t_cnt    <= '0;
      d_cnt    <= '0;
    end else begin
      estado   <= prox;
      sync_p0  <= bus.chaves;
      chaves_s <= sync_p0;
      t_cnt    <= t_prox;
      d_cnt    <= d_prox;
    end
  end

  // The latched sample is pure data: it is always reloaded before it is compared.
  always_ff @(posedge clock) begin
    amostra <= amostra_prox;
  end

  // Saturating increments keep both counters from wrapping.
  assign t_inc  = (t_cnt < T_MAX) ? t_cnt + TW'(1) : t_cnt;
  assign d_inc  = (d_cnt < D_MAX) ? d_cnt + DW'(1) : d_cnt;
  assign expira = (t_cnt >= T_LIM);
  assign zero_s = (chaves_s == '0);

  always_comb begin
    prox         = estado;
    t_prox       = t_cnt;
    d_prox       = d_cnt;
    amostra_prox = amostra;
    case (estado)
      OCIOSO: ;
      LIMPA: begin
        t_prox = '0;
        d_prox = '0;
        prox   = ESPERA;
      end
      ESPERA: begin
        t_prox = t_inc;
        if (!zero_s) begin
          amostra_prox = chaves_s;
          d_prox       = D_UM;
          prox         = (DEBOUNCE_CICLOS <= 1) ? REGISTRA : ESTABILIZA;
        end else if (expira) begin
          prox = EXPIROU;
        end
      end
      ESTABILIZA: begin
        t_prox = t_inc;
        if (zero_s) begin
          d_prox = '0;
          prox   = expira ? EXPIROU : ESPERA;
        end else if (chaves_s != amostra) begin
          amostra_prox = chaves_s;
          d_prox       = D_UM;
          if (DEBOUNCE_CICLOS <= 1) prox = REGISTRA;
          else if (expira)          prox = EXPIROU;
        end else begin
          // Completing the debounce wins over an expiry in the same cycle.
          d_prox = d_inc;
          if (d_inc == D_MAX) prox = REGISTRA;
          else if (expira)    prox = EXPIROU;
        end
      end
      REGISTRA: prox = PRONTA;
      PRONTA: begin
        if (bus.ack_jogada) begin
          d_prox = '0;
          prox   = SOLTA;
        end
      end
      SOLTA: begin
        if (zero_s) begin
          d_prox = d_inc;
          if (d_inc == D_MAX) prox = OCIOSO;
        end else begin
          d_prox = '0;
        end
      end
      EXPIROU: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
    // A new round preempts whatever is in flight, including an unacknowledged move.
    if (bus.iniciar_rodada) prox = LIMPA;
  end

  assign bus.reset_reg_jogada  = (estado == LIMPA);
  assign bus.enable_reg_jogada = (estado == REGISTRA);
  assign bus.jogada_pronta     = (estado == PRONTA);
  assign bus.timeout_jogada    = (estado == EXPIROU);
  assign bus.estado_dbg        = estado;
endmodule

// File: doc/controle_jogada.md
Name: controle_jogada

Overview:
- Sequencer for the move-register datapath: clears the move register at round start, waits for a player input on the switches, debounces it, then fires a single capture enable.
- Handshakes the captured move to the game FSM and waits for the switches to be released before re-arming.
- Flags a timeout when no valid move arrives within the move window.
- Sits between the top-level game control unit and registra_jogada; drives its enable_reg_jogada and reset_reg_jogada inputs.

Parameters:
- N_CHAVES, 6, width of the switch bus.
- DEBOUNCE_CICLOS, 4, consecutive identical nonzero samples required to accept a move (>=1).
- TIMEOUT_CICLOS, 1000, cycles allowed in the move window before timeout (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- chaves  in  N_CHAVES  raw player switches, asynchronous to clock.
- iniciar_rodada  in  1  pulse from game FSM: open a new move window.
- ack_jogada  in  1  game FSM has consumed the captured move.
- enable_reg_jogada  out  1  capture strobe to the move register.
- reset_reg_jogada  out  1  synchronous clear to the move register.
- jogada_pronta  out  1  level: a captured move is valid in the register.
- timeout_jogada  out  1  one-cycle pulse: move window expired.
- estado_dbg  out  3  current FSM state encoding, for debug display.

Behaviour:
- Sync: chaves passes through a 2-FF synchroniser (chaves_s). All decisions use chaves_s, which adds 2 cycles of input latency.
- Reset (reset_n=0, async): FSM=OCIOSO, counters=0, sync FFs=0. All outputs 0; estado_dbg=0.
- States and encodings: OCIOSO=0, LIMPA=1, ESPERA=2, ESTABILIZA=3, REGISTRA=4, PRONTA=5, SOLTA=6, EXPIROU=7.
- OCIOSO: iniciar_rodada=1 -> LIMPA.
- LIMPA (1 cycle): reset_reg_jogada=1. Clear the timeout counter -> ESPERA.
- ESPERA:
  - Timeout counter increments each cycle.
  - chaves_s!=0 -> latch the sample in amostra, set deb_cnt=1, -> ESTABILIZA.
  - Else if counter reaches TIMEOUT_CICLOS-1 -> EXPIROU.
  - A nonzero chaves_s takes priority over expiry in the same cycle.
- ESTABILIZA:
  - Timeout counter keeps running.
  - chaves_s==amostra -> deb_cnt++.
  - chaves_s changed but still nonzero -> reload amostra, deb_cnt=1.
  - chaves_s==0 -> back to ESPERA.
  - deb_cnt reaches DEBOUNCE_CICLOS -> REGISTRA.
  - Expiry in this state -> EXPIROU, unless the same cycle completes the debounce; then REGISTRA wins.
- REGISTRA (1 cycle): enable_reg_jogada=1, so the register captures chaves on this edge -> PRONTA.
  - Note: the register samples raw chaves, and debounce guarantees stability.
  - Measured from the first stable nonzero raw input, the enable asserts 2+DEBOUNCE_CICLOS cycles later.
- PRONTA: jogada_pronta=1, held until ack_jogada=1 -> SOLTA. No timeout in this state.
- SOLTA: wait for chaves_s==0 for DEBOUNCE_CICLOS consecutive cycles -> OCIOSO. Any nonzero sample restarts the count.
- EXPIROU (1 cycle): timeout_jogada=1 -> OCIOSO. The register is not written.
- iniciar_rodada in any state other than OCIOSO: restarts at LIMPA, dropping any pending move. This includes PRONTA.
- ack_jogada outside PRONTA: ignored.
- enable_reg_jogada and reset_reg_jogada are never asserted in the same cycle.
- enable_reg_jogada is asserted at most once per move window.
- Counter widths: $clog2(TIMEOUT_CICLOS+1) and $clog2(DEBOUNCE_CICLOS+1). Counters saturate and never wrap.
- Reset asserted mid-operation: immediate return to OCIOSO. Outputs drop asynchronously.

Test Plan:
- Reset then iniciar_rodada; chaves=6'b000101 held stable: reset_reg_jogada=1 for 1 cycle, enable_reg_jogada=1 exactly 6 cycles after chaves applied, then jogada_pronta=1. Register holds 000101, wire_tiro=1.
- Bounce: chaves toggles 000001/000000 every 2 cycles for 10 cycles, then stays 000001: no enable during the bounce; single enable after the stable run.
- Timeout: TIMEOUT_CICLOS=20, no input after iniciar_rodada: timeout_jogada pulses exactly once, 21 cycles after LIMPA; enable never asserts; FSM returns to OCIOSO.
- Handshake/release: after a capture, hold ack_jogada=0 for 50 cycles: jogada_pronta stays 1. Pulse ack with chaves still nonzero: FSM stays in SOLTA until chaves=0 for 4 cycles, then estado_dbg=0.
- Preemption: iniciar_rodada asserted while in ESTABILIZA, and again while in PRONTA: FSM enters LIMPA with reset_reg_jogada=1 next cycle, and jogada_pronta drops.
- Async reset: deassert reset_n mid-ESTABILIZA, between clock edges: outputs go 0 with no clock edge; after release, the FSM ignores chaves until iniciar_rodada.
